alu_issuer: RTL and testbench

//  Initiator side of the ALU operand/select -> result/flags interface.
//  - Accepts operation commands on a valid/ready stream.
//  - Reads operands from a small internal register file, or takes an immediate for B.
//  - Drives the combinational ALU top, waits for it to settle, then captures result and flags.
//  - Writes the result back and returns it on a valid/ready response stream.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issuer_rf.sv | 33 +++
 rtl/alu_issuer.sv | 134 +++++++++++++
 tb/tb_alu_issuer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions
// and the issuer state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_CMP = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_AND = 4'd7,
    OP_NOT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } op_e;

  localparam op_e OP_LAST = OP_SHR;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issuer_rf.sv
// Operand register file: two async read ports,
// one sync write port, sync clear on rst.
module alu_issuer_rf #(
  parameter  int N    = 4,
  parameter  int REGS = 4,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [N-1:0]  ra_data,
  output logic [N-1:0]  rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd
);

  logic [N-1:0] regs [REGS];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  // Clear on reset, otherwise single-port write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Issues one command at a time to a combinational ALU,
// waits SETTLE cycles, captures and returns the result.
module alu_issuer
  import alu_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int REGS   = 4,
  parameter  int SETTLE = 1,
  localparam int AW     = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic          cmd_use_imm,
  input  logic [N-1:0]  cmd_imm,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_select,
  input  logic [N-1:0]  alu_result,
  input  logic [3:0]    alu_flags,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_result,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err,
  output logic          busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  a_q, b_q;
  logic [N-1:0]  ra_data, rb_data;
  logic          accept, illegal, done, we;

  assign illegal = cmd_op > OP_LAST;
  assign accept  = cmd_valid && cmd_ready;
  assign done    = (state == S_ISSUE) && (cnt == '0);

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = op_q;

  alu_issuer_rf #(
    .N    (N),
    .REGS (REGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cmd_ra),
    .rb_addr (cmd_rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (we),
    .wa      (rd_q),
    .wd      (alu_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: illegal ops bypass ISSUE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept) state_nxt = illegal ? S_RESP : S_ISSUE;
      S_ISSUE:
        if (cnt == '0) state_nxt = S_RESP;
      S_RESP:
        if (rsp_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs and write-back enable.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
    we        = done && (op_q != OP_CMP);
  end

  // Operand latches, settle counter, response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_MOV;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        rd_q <= cmd_rd;
        cnt  <= CNT_LOAD;
        if (illegal) begin
          rsp_result <= '0;
          rsp_flags  <= '0;
          rsp_err    <= 1'b1;
        end else begin
          op_q <= cmd_op;
          a_q  <= ra_data;
          b_q  <= cmd_use_imm ? cmd_imm : rb_data;
        end
      end
      if (state == S_ISSUE) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_err    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural
// 4-bit ALU acting as the responder.
module tb_alu_issuer;
  import alu_pkg::*;

  localparam int N      = 4;
  localparam int REGS   = 4;
  localparam int SETTLE = 3;
  localparam int AW     = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0;
  logic [AW-1:0] cmd_ra = '0;
  logic [AW-1:0] cmd_rb = '0;
  logic          cmd_use_imm = 1'b0;
  logic [N-1:0]  cmd_imm = '0;
  logic [N-1:0]  alu_a, alu_b;
  logic [3:0]    alu_select;
  logic [N-1:0]  alu_result;
  logic [3:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [N-1:0]  rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [N-1:0] got_result;
  logic [3:0]   got_flags;
  logic         got_err;
  int           got_lat;

  always #5 clk = ~clk;

  alu_issuer #(
    .N      (N),
    .REGS   (REGS),
    .SETTLE (SETTLE)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_ra      (cmd_ra),
    .cmd_rb      (cmd_rb),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_select  (alu_select),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // Behavioural ALU: C is carry for ADD, borrow for SUB/CMP.
  always_comb begin
    logic [4:0] t;
    logic       v;
    t = '0;
    v = 1'b0;
    case (alu_select)
      4'd0: t = {1'b0, alu_b};
      4'd1, 4'd3: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        v = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]);
      end
      4'd2: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        v = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
      end
      4'd4: t = {1'b0, 4'(alu_a * alu_b)};
      4'd5: t = (alu_b == '0) ? 5'd0 : {1'b0, alu_a / alu_b};
      4'd6: t = {1'b0, alu_a ^ alu_b};
      4'd7: t = {1'b0, alu_a & alu_b};
      4'd8: t = {1'b0, ~alu_a};
      4'd9: t = {1'b0, alu_a << alu_b[1:0]};
      4'd10: t = {1'b0, alu_a >> alu_b[1:0]};
      default: t = '0;
    endcase
    alu_result = t[3:0];
    alu_flags  = {t[3], t[3:0] == 4'd0, t[4], v};
  end

  // Issue one command, wait for rsp_valid; leaves rsp pending.
  task automatic send(input logic [3:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic use_imm, input logic [N-1:0] imm);
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_use_imm = use_imm; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    if (!rsp_valid) begin
      n_vec++; n_bad++;
      $display("FAIL timeout op=%0h: no rsp_valid within 20 cycles", op);
    end
    got_result = rsp_result;
    got_flags  = rsp_flags;
    got_err    = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic use_imm, input logic [N-1:0] imm);
    send(op, rd, ra, rb, use_imm, imm);
    finish_rsp();
  endtask

  // Read rf[i] by ADD rd=i ra=i imm=0 (writes same value back).
  task automatic read_reg(input int i, output logic [N-1:0] v);
    run_op(OP_ADD, AW'(i), AW'(i), '0, 1'b1, '0);
    v = got_result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({cmd_ready, rsp_valid, busy, rsp_err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 1000",
               {cmd_ready, rsp_valid, busy, rsp_err});
    end
    n_vec++;
    if ({alu_a, alu_b, alu_select, rsp_result, rsp_flags} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 00000",
               {alu_a, alu_b, alu_select, rsp_result, rsp_flags});
    end
  endtask

  task automatic test_mov();
    send(OP_MOV, 2'd1, 2'd0, 2'd0, 1'b1, 4'h5);
    n_vec++;
    if (got_lat !== SETTLE + 1) begin
      n_bad++;
      $display("FAIL mov_latency got %0d want %0d", got_lat, SETTLE + 1);
    end
    finish_rsp();
    n_vec++;
    if ({got_err, got_result, got_flags} !== 9'h050) begin
      n_bad++;
      $display("FAIL mov got err/res/flg %h want 050",
               {got_err, got_result, got_flags});
    end
    run_op(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'h0);
    n_vec++;
    if (got_result !== 4'h5) begin
      n_bad++;
      $display("FAIL mov_readback got %h want 5", got_result);
    end
  endtask

  task automatic test_add_zero();
    logic [N-1:0] v;
    run_op(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 4'hB);
    n_vec++;
    if (got_result !== 4'h0 || got_flags[FLG_Z] !== 1'b1) begin
      n_bad++;
      $display("FAIL add_wrap got res %h z %b want 0 1",
               got_result, got_flags[FLG_Z]);
    end
    n_vec++;
    if (got_flags !== 4'b0110) begin
      n_bad++;
      $display("FAIL add_flags got %b want 0110", got_flags);
    end
    read_reg(1, v);
    n_vec++;
    if (v !== 4'h0) begin
      n_bad++;
      $display("FAIL add_wb rf1 got %h want 0", v);
    end
  endtask

  task automatic test_cmp();
    logic [N-1:0] v;
    logic [N-1:0] exp_rf [4];
    exp_rf = '{4'h0, 4'h0, 4'h5, 4'h9};
    run_op(OP_MOV, 2'd3, 2'd0, 2'd0, 1'b1, 4'h9);
    run_op(OP_CMP, 2'd3, 2'd1, 2'd2, 1'b0, 4'hF);
    n_vec++;
    if ({got_err, got_result, got_flags} !== 9'h0BA) begin
      n_bad++;
      $display("FAIL cmp got err/res/flg %h want 0ba",
               {got_err, got_result, got_flags});
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_vec++;
      if (v !== exp_rf[i]) begin
        n_bad++;
        $display("FAIL cmp_rf%0d got %h want %h", i, v, exp_rf[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [N-1:0] v;
    send(4'hE, 2'd2, 2'd3, 2'd3, 1'b1, 4'h7);
    n_vec++;
    if (got_lat !== 1) begin
      n_bad++;
      $display("FAIL ill_latency got %0d want 1", got_lat);
    end
    n_vec++;
    if ({got_err, got_result, got_flags} !== 9'h100) begin
      n_bad++;
      $display("FAIL ill_rsp got err/res/flg %h want 100",
               {got_err, got_result, got_flags});
    end
    n_vec++;
    if (alu_select !== 4'(OP_ADD)) begin
      n_bad++;
      $display("FAIL ill_select got %h want 2", alu_select);
    end
    finish_rsp();
    read_reg(2, v);
    n_vec++;
    if (v !== 4'h5 || got_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_nowb rf2 %h err %b want 5 0", v, got_err);
    end
  endtask

  task automatic test_stall();
    send(OP_XOR, 2'd0, 2'd2, 2'd0, 1'b1, 4'hF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_result, rsp_flags}
          !== 11'b100_1010_1000) begin
        n_bad++;
        $display("FAIL stall_c%0d got v/rdy/err/res/flg %b want 10010101000",
                 c, {rsp_valid, cmd_ready, rsp_err, rsp_result, rsp_flags});
      end
    end
    finish_rsp();
    n_vec++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL stall_release got v/rdy/busy %b want 010",
               {rsp_valid, cmd_ready, busy});
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [N-1:0] v;
    @(negedge clk);
    cmd_op = OP_MOV; cmd_rd = 2'd3; cmd_ra = '0; cmd_rb = '0;
    cmd_use_imm = 1'b1; cmd_imm = 4'h7; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (SETTLE - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, rsp_valid, cmd_ready, alu_select, alu_a} !== 11'b001_0000_0000) begin
      n_bad++;
      $display("FAIL rst_issue got busy/v/rdy/sel/a %b want 00100000000",
               {busy, rsp_valid, cmd_ready, alu_select, alu_a});
    end
    read_reg(3, v);
    n_vec++;
    if (v !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_nowb rf3 got %h want 0", v);
    end
    send(OP_MOV, 2'd0, 2'd0, 2'd0, 1'b1, 4'h3);
    finish_rsp();
    n_vec++;
    if (got_lat !== SETTLE + 1 || got_result !== 4'h3 || got_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after got lat %0d res %h err %b want %0d 3 0",
               got_lat, got_result, got_err, SETTLE + 1);
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add_zero();
    test_cmp();
    test_illegal();
    test_stall();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
